// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one memory port between instruction fetch and
// the load/store path, one transaction at a time, data-first with a fetch starvation guard.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY_IF,
        ST_BUSY_D,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    // Arbitration, memory sequencing and response capture
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rvalid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!reset) begin
                    // Fetch wins uncontended, or once data has starved it long enough
                    if (if_req && (!d_req || starve_q == STARVE_MAX)) begin
                        if_gnt      = 1'b1;
                        state_d     = ST_BUSY_IF;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        starve_d    = '0;
                    end else if (d_req) begin
                        d_gnt       = 1'b1;
                        state_d     = ST_BUSY_D;
                        mem_req_d   = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        if (if_req && starve_q != STARVE_MAX) begin
                            starve_d = starve_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_BUSY_IF: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    if_rdata_d  = mem_rdata;
                    if_rvalid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_BUSY_D: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    d_rdata_d  = mem_we_q ? '0 : mem_rdata;
                    d_rvalid_d = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-timeline model (grant cycle, ack cycle, expected response).
module tb_mem_arbiter;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Transaction-timeline model
    bit          act;
    int          gnt_c, ack_c, wait_left, starve;
    bit          acked, t_is_d, t_we;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [31:0] exp_if_rdata, exp_d_rdata;
    bit          exp_ifg, exp_dg;

    // Memory / environment knobs
    int          force_wait = -1;
    bit          ack_noise  = 1'b0;
    bit          force_ack  = 1'b0;
    bit          use_fixed  = 1'b0;
    logic [31:0] fixed_rdata;

    // Observations of the DUT, used only for directed timing checks
    int        last_ifg_cyc, last_ifv_cyc, last_dg_cyc;
    int        ifv_count, dv_count, gcount;
    logic [9:0] gseq;

    task automatic run_cycle();
        bit exp_mreq, exp_ifv, exp_dv, ifw, dw;
        exp_mreq = act && (cyc > gnt_c) && !acked;
        if (exp_mreq) mem_ack = (wait_left == 0);
        else          mem_ack = force_ack || (ack_noise && $urandom_range(0, 3) == 0);
        mem_rdata = use_fixed ? fixed_rdata : 32'($urandom);
        exp_ifv = act && acked && (cyc == ack_c + 1) && !t_is_d;
        exp_dv  = act && acked && (cyc == ack_c + 1) && t_is_d;
        if (exp_ifv) exp_if_rdata = t_rdata;
        if (exp_dv)  exp_d_rdata  = t_rdata;
        ifw = !reset && !act && if_req && (!d_req || starve == int'(STARVE_LIMIT));
        dw  = !reset && !act && d_req && !ifw;
        #1;
        check_eq("if_gnt", 32'(if_gnt), 32'(ifw));
        check_eq("d_gnt", 32'(d_gnt), 32'(dw));
        check_eq("mem_req", 32'(mem_req), 32'(exp_mreq));
        check_eq("mem_we", 32'(mem_we), 32'(exp_mreq ? t_we : 1'b0));
        if (exp_mreq) begin
            check_eq("mem_addr", mem_addr, t_addr);
            check_eq("mem_wdata", mem_wdata, t_wdata);
        end
        check_eq("if_rvalid", 32'(if_rvalid), 32'(exp_ifv));
        check_eq("d_rvalid", 32'(d_rvalid), 32'(exp_dv));
        check_eq("if_rdata", if_rdata, exp_if_rdata);
        check_eq("d_rdata", d_rdata, exp_d_rdata);

        if (if_gnt) last_ifg_cyc = cyc;
        if (d_gnt)  last_dg_cyc  = cyc;
        if (if_gnt || d_gnt) begin
            gseq = {gseq[8:0], if_gnt};
            gcount++;
        end
        if (if_rvalid) begin
            last_ifv_cyc = cyc;
            ifv_count++;
        end
        if (d_rvalid) dv_count++;

        if (exp_mreq) begin
            if (mem_ack) begin
                acked   = 1'b1;
                ack_c   = cyc;
                t_rdata = t_we ? 32'h0 : mem_rdata;
            end else begin
                wait_left--;
            end
        end
        if (exp_ifv || exp_dv) act = 1'b0;
        if (ifw || dw) begin
            act       = 1'b1;
            acked     = 1'b0;
            gnt_c     = cyc;
            t_is_d    = dw;
            t_we      = dw ? d_we : 1'b0;
            t_addr    = dw ? d_addr : if_addr;
            t_wdata   = dw ? d_wdata : 32'h0;
            wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
            if (ifw) starve = 0;
            else if (if_req && starve < int'(STARVE_LIMIT)) starve++;
        end
        if (reset) begin
            act          = 1'b0;
            starve       = 0;
            exp_if_rdata = 32'h0;
            exp_d_rdata  = 32'h0;
        end
        exp_ifg = ifw;
        exp_dg  = dw;
        cyc++;
        @(negedge clk);
    endtask

    // Run until requests are served and nothing is in flight; requesters drop on grant
    task automatic run_until_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_ifg) if_req = 1'b0;
            if (exp_dg)  d_req  = 1'b0;
            if (!act && !if_req && !d_req) break;
            run_cycle();
        end
        check_eq("idle_timeout", 32'(act || if_req || d_req), 32'h0);
    endtask

    task automatic drive_random();
        if (exp_ifg) if_req = 1'b0;
        else if (if_req && $urandom_range(0, 15) == 0) if_req = 1'b0;
        else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req  = 1'b1;
            if_addr = 32'($urandom);
        end
        if (exp_dg) d_req = 1'b0;
        else if (d_req && $urandom_range(0, 15) == 0) d_req = 1'b0;
        else if (!d_req && $urandom_range(0, 1) == 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = 32'($urandom);
            d_wdata = 32'($urandom);
        end
        reset = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        int snap_a, snap_b;
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0; fixed_rdata = '0;
        act = 1'b0; acked = 1'b0; starve = 0; gnt_c = 0; ack_c = 0; wait_left = 0;
        t_is_d = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; t_rdata = '0;
        exp_if_rdata = '0; exp_d_rdata = '0; exp_ifg = 1'b0; exp_dg = 1'b0;
        last_ifg_cyc = 0; last_ifv_cyc = 0; last_dg_cyc = 0;
        ifv_count = 0; dv_count = 0; gcount = 0; gseq = '0;
        repeat (2) @(negedge clk);

        // Reset state: requests present while reset is high yield no grant
        if_req = 1'b1; d_req = 1'b1;
        run_cycle(); run_cycle();
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
        run_cycle();

        // Fetch only, memory acks two cycles after mem_req
        if_req = 1'b1; if_addr = 32'h10; force_wait = 2;
        use_fixed = 1'b1; fixed_rdata = 32'h0050_0093;
        run_until_idle(20);
        check_eq("fetch_latency", 32'(last_ifv_cyc - last_ifg_cyc), 32'd4);
        check_eq("fetch_rdata", if_rdata, 32'h0050_0093);
        use_fixed = 1'b0;

        // Contention, zero-wait memory, both requesters held
        if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        force_wait = 0; gcount = 0; gseq = '0;
        for (int i = 0; i < 100 && gcount < 10; i++) run_cycle();
        check_eq("contention_order", 32'(gseq), 32'(10'b00001_00001));
        if_req = 1'b0; d_req = 1'b0;
        run_until_idle(20);

        // Store with one wait state
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'hDEAD_BEEF; force_wait = 1;
        snap_a = ifv_count; snap_b = dv_count;
        run_until_idle(20);
        check_eq("store_rdata", d_rdata, 32'h0);
        check_eq("store_no_ifv", 32'(ifv_count - snap_a), 32'h0);
        check_eq("store_dv", 32'(dv_count - snap_b), 32'h1);

        // Hold check: 5-cycle stall while the load requester toggles
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; force_wait = 5;
        run_cycle();
        snap_a = gcount;
        for (int i = 0; i < 7; i++) begin
            d_req = 1'($urandom_range(0, 1)); d_addr = 32'($urandom);
            run_cycle();
        end
        check_eq("hold_no_gnt", 32'(gcount - snap_a), 32'h0);
        d_req = 1'b1; d_addr = 32'h480;
        run_cycle();
        check_eq("hold_regrant", 32'(last_dg_cyc), 32'(cyc - 1));
        run_until_idle(20);

        // Reset in the second busy cycle, stray ack after reset drops
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; force_wait = 10;
        snap_b = dv_count;
        run_cycle();
        d_req = 1'b0;
        run_cycle();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0; force_ack = 1'b1;
        run_cycle();
        force_ack = 1'b0;
        check_eq("rst_no_dvalid", 32'(dv_count - snap_b), 32'h0);
        if_req = 1'b1; if_addr = 32'h44; force_wait = 1; snap_a = ifv_count;
        run_until_idle(20);
        check_eq("rst_fetch_served", 32'(ifv_count - snap_a), 32'h1);

        // Spurious acks while idle
        force_ack = 1'b1; snap_a = ifv_count; snap_b = dv_count;
        repeat (5) run_cycle();
        force_ack = 1'b0;
        check_eq("spurious_ack", 32'((ifv_count - snap_a) + (dv_count - snap_b)), 32'h0);

        // Random traffic with random wait states, stray acks and occasional resets
        force_wait = -1; ack_noise = 1'b1;
        repeat (3000) begin
            drive_random();
            run_cycle();
        end
        reset = 1'b0; ack_noise = 1'b0;
        run_until_idle(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
